// File: rtl/lock_pkg.sv
// Shared types and constants for the match-driven lock controller:
// FSM state encoding, alarm display pattern and the hex glyph table.
package lock_pkg;

    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        OPEN   = 2'd1,
        ALARM  = 2'd2
    } lock_state_t;

    localparam logic [7:0] SEG_ALARM = 8'h77;

    // Entry [n] is the a..g pattern for hex digit n (bit0 = a).
    localparam logic [15:0][6:0] SEG_GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex digit to active-high 7-segment pattern (bit0 = a .. bit6 = g).
module hex_to_seg
    import lock_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_GLYPHS[hex];

endmodule

// File: rtl/match_lock_ctrl.sv
// Lock controller: turns rising edges of the detector match level into timed
// unlock windows, counts failed attempts and latches an alarm.
module match_lock_ctrl
    import lock_pkg::*;
#(
    parameter int TIMEOUT_BITS = 12,
    parameter int MAX_FAILS    = 3,
    parameter int OPEN_CYCLES  = 8
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic       match_in,
    input  logic       bit_valid,
    output logic       unlocked,
    output logic       alarm,
    output logic [1:0] fails,
    output logic [3:0] match_count,
    output logic [7:0] SEG
);

    lock_state_t state_r;
    logic        match_d_r;
    logic [3:0]  bitcnt_r;
    logic [7:0]  opencnt_r;
    logic [1:0]  fails_r;
    logic [3:0]  match_count_r;
    logic        unlocked_r;
    logic        alarm_r;

    logic        match_event_s;
    logic [2:0]  fails_inc_s;
    logic [6:0]  glyph_s;
    logic [7:0]  seg_s;

    // A level held high is one event; match_d_r clears on reset so a high level at release counts.
    assign match_event_s = match_in & ~match_d_r;
    assign fails_inc_s   = {1'b0, fails_r} + 3'd1;

    // Lock FSM with all outputs registered alongside the state.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_r       <= LOCKED;
            match_d_r     <= 1'b0;
            bitcnt_r      <= 4'd0;
            opencnt_r     <= 8'd0;
            fails_r       <= 2'd0;
            match_count_r <= 4'd0;
            unlocked_r    <= 1'b0;
            alarm_r       <= 1'b0;
        end else begin
            match_d_r <= match_in;
            case (state_r)
                LOCKED: begin
                    if (match_event_s) begin
                        match_count_r <= match_count_r + 4'd1;
                        fails_r       <= 2'd0;
                        bitcnt_r      <= 4'd0;
                        opencnt_r     <= 8'(OPEN_CYCLES);
                        state_r       <= OPEN;
                        unlocked_r    <= 1'b1;
                    end else if (bit_valid) begin
                        if (bitcnt_r == 4'(TIMEOUT_BITS - 1)) begin
                            bitcnt_r <= 4'd0;
                            fails_r  <= fails_inc_s[1:0];
                            if (fails_inc_s == 3'(MAX_FAILS)) begin
                                state_r <= ALARM;
                                alarm_r <= 1'b1;
                            end
                        end else begin
                            bitcnt_r <= bitcnt_r + 4'd1;
                        end
                    end
                end
                OPEN: begin
                    // A fresh event restarts the full window, even on its last cycle.
                    if (match_event_s) begin
                        match_count_r <= match_count_r + 4'd1;
                        opencnt_r     <= 8'(OPEN_CYCLES);
                    end else if (opencnt_r == 8'd1) begin
                        opencnt_r  <= 8'd0;
                        bitcnt_r   <= 4'd0;
                        state_r    <= LOCKED;
                        unlocked_r <= 1'b0;
                    end else begin
                        opencnt_r <= opencnt_r - 8'd1;
                    end
                end
                ALARM: begin
                    state_r <= ALARM;
                end
                default: begin
                    state_r    <= LOCKED;
                    unlocked_r <= 1'b0;
                    alarm_r    <= 1'b0;
                end
            endcase
        end
    end

    hex_to_seg u_hex_to_seg (
        .hex (match_count_r),
        .seg (glyph_s)
    );

    // Display mux: alarm pattern overrides the count, dp mirrors the unlock window.
    always_comb begin
        seg_s = 8'h00;
        if (state_r == ALARM) begin
            seg_s = SEG_ALARM;
        end else begin
            seg_s = {unlocked_r, glyph_s};
        end
    end

    assign unlocked    = unlocked_r;
    assign alarm       = alarm_r;
    assign fails       = fails_r;
    assign match_count = match_count_r;
    assign SEG         = seg_s;

endmodule

// File: tb/tb_match_lock_ctrl.sv
// Table-driven bench for match_lock_ctrl: vectors carry inputs plus expected
// outputs; expectations are queued when driven and popped after the edge.
module tb_match_lock_ctrl;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b1;
    logic       match_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       unlocked;
    logic       alarm;
    logic [1:0] fails;
    logic [3:0] match_count;
    logic [7:0] SEG;

    typedef struct {
        logic        rst;
        logic        m;
        logic        bv;
        logic [15:0] exp;   // {unlocked, alarm, fails, match_count, SEG}
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] sb[$];
    int          errors = 0;
    int          checks = 0;

    logic [7:0] glyph [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    match_lock_ctrl #(.TIMEOUT_BITS(12), .MAX_FAILS(3), .OPEN_CYCLES(8)) dut (
        .clk_2       (clk_2),
        .reset       (reset),
        .match_in    (match_in),
        .bit_valid   (bit_valid),
        .unlocked    (unlocked),
        .alarm       (alarm),
        .fails       (fails),
        .match_count (match_count),
        .SEG         (SEG)
    );

    always #5 clk_2 = ~clk_2;

    function automatic logic [7:0] seg_of(input logic [3:0] cnt, input logic unl, input logic alm);
        logic [7:0] g;
        g = glyph[cnt];
        if (alm) return 8'h77;
        return {unl, g[6:0]};
    endfunction

    task automatic add(input logic r, input logic m, input logic bv, input logic unl,
                       input logic alm, input logic [1:0] f, input logic [3:0] c);
        vec_t v;
        v.rst = r;
        v.m   = m;
        v.bv  = bv;
        v.exp = {unl, alm, f, c, seg_of(c, unl, alm)};
        vecs.push_back(v);
    endtask

    initial begin
        logic [15:0] got;
        logic [15:0] want;
        logic [3:0]  cnt;

        // Reset, idle, one pulse opening the lock for exactly 8 cycles.
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
        for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'd1);
        for (int i = 0; i < 7; i++) add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd1);

        // Three timeouts of 12 bits each: fails 1, 2, then alarm.
        for (int r = 0; r < 3; r++) begin
            for (int b = 0; b < 12; b++) begin
                if (b == 11) add(1'b0, 1'b0, 1'b1, 1'b0, (r == 2), 2'(r + 1), 4'd1);
                else         add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'(r), 4'd1);
            end
        end
        // Alarm is absorbing: events and bits ignored, counts frozen.
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 4'd1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 4'd1);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 4'd1);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 4'd1);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);

        // Event on the 12th bit wins over the timeout.
        for (int i = 0; i < 11; i++) add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'd1);
        // Second event in OPEN reloads the window; bits in OPEN are ignored.
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd1);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'd2);
        for (int i = 0; i < 7; i++) add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'd2);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2);
        // Bit counter restarted from 0 on leaving OPEN: 12th bit is the first failure.
        for (int i = 0; i < 11; i++) add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd2);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 4'd2);

        // Fifteen more pulses: 17 events since reset, count wraps to 1.
        cnt = 4'd2;
        for (int i = 0; i < 15; i++) begin
            cnt = cnt + 4'd1;
            add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, cnt);
            add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, cnt);
        end

        // Reset mid-OPEN with match held high across release: exactly one event.
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'd1);
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'd1);
        for (int i = 0; i < 4; i++) add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd1);

        for (int k = 0; k < vecs.size(); k++) begin
            reset     = vecs[k].rst;
            match_in  = vecs[k].m;
            bit_valid = vecs[k].bv;
            sb.push_back(vecs[k].exp);
            @(posedge clk_2);
            #1;
            got = {unlocked, alarm, fails, match_count, SEG};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL vec%0d scoreboard empty got=%h", k, got);
            end else begin
                want = sb.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL vec%0d {unl,alm,fails,cnt,seg} got=%h exp=%h", k, got, want);
                end
            end
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/match_lock_ctrl.md
# match_lock_ctrl

Lock controller that consumes the registered match level from the serial pattern detector (the 1101 detector driven by `SWI[1]` bit strobes) and turns it into unlock/alarm behaviour on the board. It counts match events, opens the lock for a fixed window, counts failed attempts (too many bits without a match) and latches an alarm after too many failures. It also drives the 7-segment display with the match count. It sits directly downstream of the detector in `top`, taking the detector's `LED[7]` output as `match_in` and the same `SWI[1]` strobe as `bit_valid`.

## Interface
Parameters:
- `TIMEOUT_BITS`, 12: consumed bits without a match that count as one failed attempt; legal range 2..15.
- `MAX_FAILS`, 3: failed attempts that trigger the alarm; legal range 1..3.
- `OPEN_CYCLES`, 8: cycles `unlocked` stays high per open; legal range 1..255.

Ports:
- `clk_2`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  synchronous reset, active-high.
- `match_in`  input  1  registered match level from the detector; the block responds to its rising edge only.
- `bit_valid`  input  1  high in a cycle where the detector consumed a bit.
- `unlocked`  output  1  high while in OPEN.
- `alarm`  output  1  high while in ALARM.
- `fails`  output  2  failed-attempt count since the last match.
- `match_count`  output  4  match events accepted, modulo 16.
- `SEG`  output  8  7-segment pattern, active-high; bit0=a … bit6=g, bit7=dp.

## Operation
- Event detection: `match_d` register holds the previous `match_in`. Event = `match_in & ~match_d`. `match_d` resets to 0, so `match_in` already high when `reset` falls is an event.
- States: LOCKED, OPEN, ALARM. Reset state is LOCKED.
- LOCKED, event present:
  - `match_count`+1, wrapping F→0.
  - `fails` ← 0 and `bitcnt` ← 0.
  - `opencnt` ← `OPEN_CYCLES`; go to OPEN.
- LOCKED, no event, `bit_valid` high:
  - If `bitcnt == TIMEOUT_BITS-1`: `bitcnt` ← 0 and `fails`+1. If `fails+1 == MAX_FAILS`, go to ALARM.
  - Otherwise `bitcnt`+1.
- Simultaneous event and timeout: the event wins and no failure is counted.
- OPEN:
  - `opencnt` decrements every cycle. When `opencnt == 1`, go to LOCKED with `bitcnt` = 0.
  - An event in OPEN: `match_count`+1 and `opencnt` reloads to `OPEN_CYCLES`.
  - `bit_valid` is ignored; `bitcnt` is held at 0.
- ALARM: absorbing until `reset`. Events and `bit_valid` are ignored, and `match_count` and `fails` are frozen.
- SEG:
  - LOCKED/OPEN: hex glyph of `match_count` on bits 6:0, with `dp = unlocked`.
  - ALARM: 8'h77 ('A', dp off).
  - Glyphs: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71.
- Width rules: `bitcnt` 4 bits, `opencnt` 8 bits, `fails` 2 bits. None can overflow within the legal parameter ranges.

## Timing
- All outputs are registered or decoded only from registered state; there is no combinational path from inputs to outputs.
- Latency: `match_in` first sampled high at edge k gives updated `match_count`, `unlocked` and `SEG` immediately after edge k.
- `unlocked` is high for exactly `OPEN_CYCLES` consecutive cycles after a single event.
- Reset values, after a reset edge:
  - `unlocked`=0, `alarm`=0, `fails`=0, `match_count`=0.
  - `SEG`=8'h3F.
  - State LOCKED; `bitcnt`, `opencnt` and `match_d` all 0.
- Reset has priority in every state, including mid-OPEN and ALARM.
- A `match_in` level held high produces exactly one event.

## Structure
- Package `lock_pkg` holds:
  - the `lock_state_t` enum {LOCKED, OPEN, ALARM};
  - the `SEG_ALARM` constant (8'h77);
  - the 16-entry glyph constants.
- Sub-module `hex_to_seg` (4-bit in, 7-bit out, combinational) is instantiated once. The dp bit and alarm override are muxed in `match_lock_ctrl`.
- Integration into `top`: `match_in` ← detector match, `bit_valid` ← `SWI[1]`, `LED[6]` ← `unlocked`, `LED[5]` ← `alarm`, `SEG` ← `SEG`.

## Test plan
- Reset, then idle 5 cycles → `SEG`=3F, `unlocked`=0, `alarm`=0, `match_count`=0.
- One `match_in` pulse → next edge `match_count`=1, `SEG`=86 (glyph 06 with dp); `unlocked` high for exactly 8 cycles, then `SEG`=06.
- 12 `bit_valid` cycles with no match, three times (defaults) → `fails` steps 1, 2, then `alarm`=1 and `SEG`=77. A later `match_in` pulse leaves `match_count` unchanged; only `reset` clears the alarm.
- Event on the same edge as the 12th `bit_valid` → no failure counted, `fails`=0, state OPEN.
- Second event 3 cycles into OPEN → `match_count`=2 and `unlocked` stays high 8 cycles from the second event; 17 total events → `match_count` wraps to 1.
- `reset` mid-OPEN, and `match_in` held high across reset release → `unlocked` drops on the reset edge, then one event is counted (`match_count`=1) on the first non-reset edge, and no further events while the level stays high.
